// File: rtl/mac_acc_ctrl.sv
// mac_acc_ctrl: sequences N_TERMS operand pairs through an external 4x4
// multiplier and accumulates the 8-bit products into an ACC_W-bit sum.
// The multiplier handshake is start pulse / done level: the block waits for
// done to fall (the multiplier has left its previous done state) and then to
// rise again before it takes the product.
// Optional feature: define MAC_SATURATE_EN to clamp the accumulator at
// all-ones on overflow; when it is undefined the accumulator wraps. In both
// builds ovf is a sticky flag for the current dot product.
module mac_acc_ctrl #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             x_valid,
    input  logic [3:0]       x_a,
    input  logic [3:0]       x_b,
    output logic             x_ready,
    output logic             m_start,
    output logic [3:0]       m_a,
    output logic [3:0]       m_b,
    input  logic [7:0]       m_out,
    input  logic             m_done,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    output logic             busy,
    output logic             ovf
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        ISSUE   = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4,
        ACC     = 3'd5,
        RESULT  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               ovf_q,   ovf_d;
    logic [3:0]         ma_q,    ma_d;
    logic [3:0]         mb_q,    mb_d;
    logic [7:0]         prod_q,  prod_d;
    logic [ACC_W:0]     sum_acc;

    // Adds a product to the accumulator; bit ACC_W of the result is the
    // unsigned carry, the low ACC_W bits are the new accumulator value.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [7:0]       p);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W + 1 - 8){1'b0}}, p};
`ifdef MAC_SATURATE_EN
        // Once clamped, every later add carries again, so the value stays
        // pinned at all-ones for the rest of the dot product.
        if (s[ACC_W]) begin
            s[ACC_W-1:0] = '1;
        end
`endif
        return s;
    endfunction

    assign sum_acc = acc_add(acc_q, prod_q);

    // Next-state and datapath update for the sequencing FSM.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (x_valid) begin
                    ma_d    = x_a;
                    mb_d    = x_b;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!m_done) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // The product is captured only on the cycle done is seen high.
                if (m_done) begin
                    prod_d  = m_out;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d   = sum_acc[ACC_W-1:0];
                ovf_d   = ovf_q | sum_acc[ACC_W];
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST_TERM) ? RESULT : FETCH;
            end
            RESULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ma_q    <= '0;
            mb_q    <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            prod_q  <= prod_d;
        end
    end

    assign x_ready   = (state_q == FETCH);
    assign m_start   = (state_q == ISSUE);
    assign acc_valid = (state_q == RESULT);
    assign busy      = (state_q != IDLE);
    assign m_a       = ma_q;
    assign m_b       = mb_q;
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_acc_ctrl.sv
// Bench for mac_acc_ctrl: u0 uses the default parameters, u1 uses ACC_W=8,
// N_TERMS=2 to reach overflow. Expected overflow results follow
// MAC_SATURATE_EN in the same way as the design.
module tb_mac_acc_ctrl;

    localparam int N0 = 4;
    localparam int W0 = 12;
    localparam int N1 = 2;
    localparam int W1 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    // u0 signals
    logic          go = 1'b0, x_valid = 1'b0;
    logic [3:0]    x_a = 4'd0, x_b = 4'd0;
    logic          x_ready, m_start, acc_valid, busy, ovf;
    logic [3:0]    m_a, m_b;
    logic [7:0]    m_out = 8'd0;
    logic          m_done = 1'b0;
    logic [W0-1:0] acc_out;

    // u1 signals
    logic          go1 = 1'b0, xv1 = 1'b0;
    logic [3:0]    xa1 = 4'd0, xb1 = 4'd0;
    logic          xr1, ms1, av1, busy1, ovf1;
    logic [3:0]    ma1, mb1;
    logic [7:0]    mo1 = 8'd0;
    logic          md1 = 1'b0;
    logic [W1-1:0] acc1;

    int checks   = 0;
    int failures = 0;

    mac_acc_ctrl #(.N_TERMS(N0), .ACC_W(W0)) u0 (
        .clk(clk), .rst(rst), .go(go), .x_valid(x_valid), .x_a(x_a), .x_b(x_b),
        .x_ready(x_ready), .m_start(m_start), .m_a(m_a), .m_b(m_b),
        .m_out(m_out), .m_done(m_done), .acc_out(acc_out),
        .acc_valid(acc_valid), .busy(busy), .ovf(ovf)
    );

    mac_acc_ctrl #(.N_TERMS(N1), .ACC_W(W1)) u1 (
        .clk(clk), .rst(rst), .go(go1), .x_valid(xv1), .x_a(xa1), .x_b(xb1),
        .x_ready(xr1), .m_start(ms1), .m_a(ma1), .m_b(mb1),
        .m_out(mo1), .m_done(md1), .acc_out(acc1),
        .acc_valid(av1), .busy(busy1), .ovf(ovf1)
    );

    // Multiplier model for u0: after a start, done keeps its old level for
    // drop0 cycles, is low until lat0 cycles later, then rises with the product.
    int         lat0  = 2;
    int         drop0 = 0;
    int         mc0   = 0;
    logic [7:0] prod0 = 8'd0;
    always @(posedge clk) begin
        if (m_start === 1'b1) begin
            mc0   <= drop0 + lat0;
            prod0 <= m_a * m_b;
            if (drop0 == 0) m_done <= 1'b0;
        end else if (mc0 > 0) begin
            mc0 <= mc0 - 1;
            if (mc0 == 1) begin
                m_done <= 1'b1;
                m_out  <= prod0;
            end else if (mc0 - 1 <= lat0) begin
                m_done <= 1'b0;
                m_out  <= 8'hA5;
            end
        end
    end

    // Multiplier model for u1: fixed one-cycle latency.
    int         mc1   = 0;
    logic [7:0] prod1 = 8'd0;
    always @(posedge clk) begin
        if (ms1 === 1'b1) begin
            mc1   <= 1;
            prod1 <= ma1 * mb1;
            md1   <= 1'b0;
        end else if (mc1 > 0) begin
            mc1 <= 0;
            md1 <= 1'b1;
            mo1 <= prod1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Expected accumulator for an ideal (unbounded) sum of products.
    function automatic logic [31:0] model_acc(input longint s, input int w);
        longint lim;
        lim = longint'(1) << w;
        if (s >= lim) begin
`ifdef MAC_SATURATE_EN
            return 32'(lim - 1);
`else
            return 32'(s % lim);
`endif
        end
        return 32'(s);
    endfunction

    // Reference model for u0, sampled on the falling edge: tracks accepted
    // pairs since the last accepted go and checks results and held outputs.
    longint      msum   = 0;
    int          mcnt   = 0;
    bit          active = 1'b0;
    bit          armed  = 1'b0;
    logic [31:0] hold   = 32'd0;
    logic [31:0] hold_ovf = 32'd0;
    always @(negedge clk) begin
        if (armed) begin
            if (acc_valid !== 1'b0) begin
                chk("model_active", {31'd0, active}, 32'd1);
                chk("model_terms", mcnt, N0);
                chk("model_acc", acc_out, model_acc(msum, W0));
                chk("model_ovf", ovf, (msum >= (longint'(1) << W0)) ? 32'd1 : 32'd0);
                hold     = model_acc(msum, W0);
                hold_ovf = (msum >= (longint'(1) << W0)) ? 32'd1 : 32'd0;
                active   = 1'b0;
            end else if (busy === 1'b0) begin
                chk("model_idle_acc", acc_out, hold);
                chk("model_idle_ovf", ovf, hold_ovf);
                chk("model_idle_ready", x_ready, 0);
            end
        end
        if (!rst) begin
            armed    = 1'b1;
            active   = 1'b0;
            msum     = 0;
            mcnt     = 0;
            hold     = 32'd0;
            hold_ovf = 32'd0;
        end else if (busy === 1'b0 && go) begin
            active = 1'b1;
            msum   = 0;
            mcnt   = 0;
        end else if (x_valid && x_ready === 1'b1) begin
            msum += x_a * x_b;
            mcnt++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_pulse;
        go = 1'b1;
        tick;
        go = 1'b0;
    endtask

    task automatic feed(input logic [3:0] a, input logic [3:0] b);
        bit ok;
        ok = 1'b0;
        x_a = a;
        x_b = b;
        x_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (x_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("feed_accept", {31'd0, ok}, 32'd1);
        tick;
        x_valid = 1'b0;
        x_a = 4'hF;
        x_b = 4'hF;
    endtask

    task automatic wait_result(input string name, input logic [31:0] exp_acc, input logic [31:0] exp_ovf);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (acc_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_valid"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            chk({name, "_acc"}, acc_out, exp_acc);
            chk({name, "_ovf"}, ovf, exp_ovf);
            @(negedge clk);
            chk({name, "_single_pulse"}, acc_valid, 0);
            chk({name, "_hold"}, acc_out, exp_acc);
        end
        tick;
    endtask

    task automatic wait_result1(input string name, input logic [31:0] exp_acc, input logic [31:0] exp_ovf);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (av1 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_valid"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            chk({name, "_acc"}, acc1, exp_acc);
            chk({name, "_ovf"}, ovf1, exp_ovf);
            @(negedge clk);
            chk({name, "_single_pulse"}, av1, 0);
            chk({name, "_hold"}, acc1, exp_acc);
        end
        tick;
    endtask

    // Directed sequence.
    initial begin
        int pulses;
        rst = 1'b0;
        repeat (3) tick;
        rst = 1'b1;

        @(negedge clk);
        chk("rst_acc", acc_out, 0);
        chk("rst_valid", acc_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", x_ready, 0);
        chk("rst_mstart", m_start, 0);
        chk("rst_ma", m_a, 0);
        chk("rst_mb", m_b, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_u1_acc", acc1, 0);
        chk("rst_u1_busy", busy1, 0);
        tick;

        // Basic dot product: 154 + 72 + 169 + 1
        go_pulse;
        feed(4'd14, 4'd11);
        feed(4'd6, 4'd12);
        feed(4'd13, 4'd13);
        feed(4'd1, 4'd1);
        wait_result("dp_basic", 32'd396, 32'd0);

        // Stall in FETCH with invalid garbage on the operand lines
        go_pulse;
        x_a = 4'hF;
        x_b = 4'hF;
        x_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready", x_ready, 1);
            chk("stall_mstart", m_start, 0);
            chk("stall_acc", acc_out, 0);
        end
        tick;
        feed(4'd1, 4'd2);
        feed(4'd3, 4'd4);
        feed(4'd5, 4'd6);
        feed(4'd7, 4'd8);
        wait_result("dp_stall", 32'd100, 32'd0);

        // go raised while busy must be ignored: 6 + 20 + 42 + 72
        go_pulse;
        feed(4'd2, 4'd3);
        go = 1'b1;
        feed(4'd4, 4'd5);
        go = 1'b0;
        feed(4'd6, 4'd7);
        feed(4'd8, 4'd9);
        wait_result("dp_go_busy", 32'd140, 32'd0);

        // Multiplier lingers in done for 2 cycles after each start: 81+100+12+4
        drop0 = 2;
        go_pulse;
        feed(4'd9, 4'd9);
        feed(4'd10, 4'd10);
        feed(4'd3, 4'd4);
        feed(4'd2, 4'd2);
        wait_result("dp_linger", 32'd197, 32'd0);
        drop0 = 0;

        // Reset during WAIT_HI of term 2 aborts without a result
        lat0 = 4;
        go_pulse;
        feed(4'd5, 4'd5);
        feed(4'd7, 4'd7);
        tick;
        tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_acc", acc_out, 0);
        chk("abort_ovf", ovf, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_valid !== 1'b0) pulses++;
        end
        chk("abort_no_valid", pulses, 0);
        tick;
        lat0 = 2;

        // Reset wins over go in the same cycle
        rst = 1'b0;
        go  = 1'b1;
        tick;
        rst = 1'b1;
        go  = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", busy, 0);
        tick;

        // Clean run after the abort: 4 * 9
        go_pulse;
        feed(4'd3, 4'd3);
        feed(4'd3, 4'd3);
        feed(4'd3, 4'd3);
        feed(4'd3, 4'd3);
        wait_result("dp_after_abort", 32'd36, 32'd0);

        // Overflow on the narrow instance: 225 + 225 = 450
        xa1 = 4'd15;
        xb1 = 4'd15;
        xv1 = 1'b1;
        go1 = 1'b1;
        tick;
        go1 = 1'b0;
`ifdef MAC_SATURATE_EN
        wait_result1("ovf8", 32'd255, 32'd1);
`else
        wait_result1("ovf8", 32'd194, 32'd1);
`endif
        xv1 = 1'b0;

        // A new go clears the sticky ovf: 1 + 1
        xa1 = 4'd1;
        xb1 = 4'd1;
        xv1 = 1'b1;
        go1 = 1'b1;
        tick;
        go1 = 1'b0;
        wait_result1("ovf_clear", 32'd2, 32'd0);
        xv1 = 1'b0;

        repeat (3) tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mac_acc_ctrl.md
MAC_ACC_CTRL -- requirements
Module: mac_acc_ctrl

Interface
REQ-001 Parameter N_TERMS, default 4, number of products summed per dot product (range 1..16).
REQ-002 Parameter ACC_W, default 12, accumulator width (at least 8 + clog2(N_TERMS)).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 go  input  1  starts a new dot product when sampled high in IDLE.
REQ-006 x_valid  input  1  operand pair available on x_a/x_b.
REQ-007 x_a, x_b  input  4 each  unsigned operand pair.
REQ-008 x_ready  output  1  block accepts the operand pair this cycle.
REQ-009 m_start  output  1  start pulse to the 4x4 multiplier.
REQ-010 m_a, m_b  output  4 each  registered operands to the multiplier, held stable from issue until the product is consumed.
REQ-011 m_out  input  8  multiplier product.
REQ-012 m_done  input  1  multiplier done flag.
REQ-013 acc_out  output  ACC_W  accumulated sum, held stable until the next go.
REQ-014 acc_valid  output  1  one-cycle pulse marking a final result.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 ovf  output  1  sticky overflow flag for the current dot product.

Function
REQ-017 The state machine SHALL use these states: IDLE, FETCH, ISSUE, WAIT_LO, WAIT_HI, ACC, RESULT.
REQ-018 IDLE: on go=1, clear acc_out, term counter and ovf, then go to FETCH; otherwise stay.
REQ-019 FETCH: x_ready=1 only in this state; on x_valid=1, latch x_a/x_b into m_a/m_b and go to ISSUE.
REQ-020 ISSUE: m_start=1 for exactly one cycle, then go to WAIT_LO.
REQ-021 WAIT_LO: wait until m_done=0 (multiplier has left its done state), then go to WAIT_HI.
REQ-022 WAIT_HI: wait until m_done=1, then go to ACC; m_out is sampled in this cycle only.
REQ-023 ACC: acc_out <= acc_out + zero-extended m_out; increment the term counter; if the count reaches N_TERMS go to RESULT, else go to FETCH.
REQ-024 RESULT: acc_valid=1 for one cycle, then go to IDLE.
REQ-025 Latency per term, with x_valid already high: 1 (FETCH) + 1 (ISSUE) + multiplier cycles + 1 (ACC).
REQ-026 go is ignored in every state except IDLE; x_valid is ignored outside FETCH.
REQ-027 An operand pair whose x_valid drops before acceptance is not consumed; no partial capture occurs.
REQ-028 An unsigned carry out of ACC_W bits sets ovf, which stays set until the next accepted go or reset.
REQ-029 Overflow arithmetic depends on MAC_SATURATE_EN (see Configuration).

Reset
REQ-030 With rst=0 at a clock edge, the block SHALL enter IDLE and set acc_out=0, acc_valid=0, ovf=0, busy=0, x_ready=0, m_start=0, m_a=m_b=0, term counter=0.
REQ-031 Reset applied in any state, including mid-WAIT, SHALL abort the operation; no acc_valid pulse follows.
REQ-032 Reset has priority over go and x_valid in the same cycle.

Configuration
REQ-033 Macro MAC_SATURATE_EN defined: on overflow, acc_out clamps to all-ones (2^ACC_W-1) and stays there for the remaining terms; ovf is set.
REQ-034 Macro MAC_SATURATE_EN undefined: acc_out wraps modulo 2^ACC_W; ovf is still set.

Verification
REQ-035 Reset then go, N_TERMS=4, pairs (14,11),(6,12),(13,13),(1,1) -> acc_out=154+72+169+1=396, one acc_valid pulse, ovf=0.
REQ-036 x_valid held low for 5 cycles in FETCH -> x_ready stays 1, m_start stays 0, acc_out unchanged.
REQ-037 rst=0 asserted during WAIT_HI of term 2 -> IDLE next cycle, acc_out=0, no acc_valid pulse.
REQ-038 ACC_W=8, N_TERMS=2, pairs (15,15),(15,15) -> with macro: acc_out=255, ovf=1; without macro: acc_out=194, ovf=1.
REQ-039 go pulsed while busy -> ignored; the in-progress result completes correctly.
REQ-040 Multiplier model holding m_done=1 for 2 cycles after ISSUE before dropping -> block waits through WAIT_LO, and each product is accumulated exactly once.
